mem_stage: RTL and testbench

Memory-access pipeline stage between `exe_stage` and `wb_stage` of the five-stage MIPS core. It registers the execute-stage bus and picks up load data from the synchronous data SRAM one cycle after the request. It captures that data into a hold register when writeback stalls, and forwards the final result to the writeback stage. It also drives the store-commit pulse for the store buffer and, optionally, the MEM-stage bypass to decode.

---
 rtl/mem_stage.sv | 88 ++++++++
 tb/tb_mem_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EXE bus, holds SRAM load data across writeback stalls.
// Optional MEM-to-decode bypass is enabled by defining MS_FWD_EN.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_allowin,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [71:0] es_to_ms_bus,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    input  logic [31:0] data_sram_rdata,
    output logic        mem_we,
    output logic [31:0] ms_to_ds_result,
    output logic [4:0]  MS_dest
);

    logic        ms_valid;
    logic        ms_ready_go;
    logic [71:0] bus_r;
    logic        first_r;
    logic        hold_vld;
    logic [31:0] hold_r;

    logic        ms_mem_we;
    logic        ms_res_from_mem;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_alu_result;
    logic [31:0] ms_pc;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic        ms_leave;
    logic        hold_capture;

    assign {ms_mem_we, ms_res_from_mem, ms_gr_we, ms_dest, ms_alu_result, ms_pc} = bus_r;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_leave       = ms_to_ws_valid && ws_allowin;
    // SRAM data is only valid in the first cycle; keep it if we cannot leave then.
    assign hold_capture   = ms_valid && first_r && !ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
            first_r  <= 1'b0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            first_r <= es_to_ms_valid && ms_allowin;
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            bus_r <= es_to_ms_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_vld <= 1'b0;
            hold_r   <= 32'd0;
        end else if (ms_leave) begin
            hold_vld <= 1'b0;
        end else if (hold_capture) begin
            hold_vld <= 1'b1;
            hold_r   <= data_sram_rdata;
        end
    end

    assign load_data    = hold_vld ? hold_r : data_sram_rdata;
    assign final_result = ms_res_from_mem ? load_data : ms_alu_result;
    assign ms_to_ws_bus = {ms_gr_we, ms_dest, final_result, ms_pc};
    assign mem_we       = ms_valid && ms_mem_we && ws_allowin;

`ifdef MS_FWD_EN
    assign MS_dest         = ms_dest & {5{ms_valid && ms_gr_we}};
    assign ms_to_ds_result = final_result;
`else
    assign MS_dest         = 5'd0;
    assign ms_to_ds_result = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// checked against a transaction-level model of the stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [71:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [31:0] data_sram_rdata;
    logic        mem_we;
    logic [31:0] ms_to_ds_result;
    logic [4:0]  MS_dest;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_we          (mem_we),
        .ms_to_ds_result (ms_to_ds_result),
        .MS_dest         (MS_dest)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: the instruction currently in MEM, whether this is its first cycle,
    // and the load word that belonged to it in that first cycle.
    bit          m_valid = 1'b0;
    bit          m_first = 1'b0;
    logic [71:0] m_bus;
    logic [31:0] m_ld;

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] mk_bus(input bit st, input bit ld, input bit wr,
                                           input logic [4:0] dst, input logic [31:0] alu,
                                           input logic [31:0] pc);
        return {st, ld, wr, dst, alu, pc};
    endfunction

    task automatic drive(input bit wsa, input bit esv, input logic [71:0] bus,
                         input logic [31:0] rd);
        ws_allowin      = wsa;
        es_to_ms_valid  = esv;
        es_to_ms_bus    = bus;
        data_sram_rdata = rd;
        #1;
    endtask

    // Check all outputs against the model mid-cycle, then advance the model on the edge.
    task automatic cycle();
        logic [31:0] ld;
        logic [31:0] fin;
        @(negedge clk);
        ld  = m_first ? data_sram_rdata : m_ld;
        fin = m_bus[70] ? ld : m_bus[63:32];
        check("ms_allowin", ms_allowin, !m_valid || ws_allowin);
        check("ms_to_ws_valid", ms_to_ws_valid, m_valid);
        check("mem_we", mem_we, m_valid && m_bus[71] && ws_allowin);
        check("hold_vld", dut.hold_vld, m_valid && !m_first);
        if (m_valid) check("ms_to_ws_bus", ms_to_ws_bus, {m_bus[69:64], fin, m_bus[31:0]});
`ifdef MS_FWD_EN
        check("MS_dest", MS_dest, (m_valid && m_bus[69]) ? m_bus[68:64] : 5'd0);
        if (m_valid) check("ms_to_ds_result", ms_to_ds_result, fin);
`else
        check("MS_dest", MS_dest, 5'd0);
        check("ms_to_ds_result", ms_to_ds_result, 32'd0);
`endif
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0;
            m_first = 1'b0;
        end else begin
            if (m_first) m_ld = data_sram_rdata;
            if (!m_valid || ws_allowin) begin
                m_valid = es_to_ms_valid;
                m_first = es_to_ms_valid;
                if (es_to_ms_valid) m_bus = es_to_ms_bus;
            end else begin
                m_first = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b0, 72'd0, 32'd0);
        @(posedge clk);
        #1;
        cycle();
        check("reset_allowin", ms_allowin, 1'b1);
        check("reset_valid", ms_to_ws_valid, 1'b0);
        check("reset_mem_we", mem_we, 1'b0);
        check("reset_MS_dest", MS_dest, 5'd0);
        reset = 1'b0;

        // ALU op passes straight through
        drive(1'b1, 1'b1, mk_bus(0, 0, 1, 5'd5, 32'h0000_1234, 32'hbfc0_0000), 32'h0);
        cycle();
        drive(1'b1, 1'b0, 72'd0, 32'hffff_ffff);
        check("alu_valid", ms_to_ws_valid, 1'b1);
        check("alu_final", ms_to_ws_bus[63:32], 32'h0000_1234);
`ifdef MS_FWD_EN
        check("alu_fwd_dest", MS_dest, 5'd5);
        check("alu_fwd_result", ms_to_ds_result, 32'h0000_1234);
`endif
        cycle();

        // Load stalled three cycles keeps the first-cycle data
        drive(1'b1, 1'b1, mk_bus(0, 1, 1, 5'd3, 32'h100, 32'hbfc0_0010), 32'h0);
        cycle();
        drive(1'b0, 1'b0, 72'd0, 32'hdead_beef);
        check("ld_stall0", ms_to_ws_bus[63:32], 32'hdead_beef);
        cycle();
        for (int i = 1; i < 4; i++) begin
            drive(i == 3, 1'b0, 72'd0, 32'h0);
            check("ld_stall_hold", ms_to_ws_bus[63:32], 32'hdead_beef);
            check("ld_stall_valid", ms_to_ws_valid, 1'b1);
            cycle();
        end
        check("ld_left", ms_to_ws_valid, 1'b0);
        check("ld_hold_clr", dut.hold_vld, 1'b0);

        // Store commits once, on exit
        drive(1'b1, 1'b1, mk_bus(1, 0, 0, 5'd0, 32'h200, 32'hbfc0_0020), 32'h0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(i == 2, 1'b0, 72'd0, 32'h0);
            check("st_pulse", mem_we, i == 2);
            cycle();
        end
        check("st_after", mem_we, 1'b0);

        // Back-to-back loads
        drive(1'b1, 1'b1, mk_bus(0, 1, 1, 5'd1, 32'h0, 32'hbfc0_0030), 32'h0);
        cycle();
        drive(1'b1, 1'b1, mk_bus(0, 1, 1, 5'd2, 32'h0, 32'hbfc0_0034), 32'h11);
        check("b2b_a", ms_to_ws_bus[63:32], 32'h11);
        cycle();
        drive(1'b1, 1'b0, 72'd0, 32'h22);
        check("b2b_b", ms_to_ws_bus[63:32], 32'h22);
        check("b2b_pc", ms_to_ws_bus[31:0], 32'hbfc0_0034);
        check("b2b_nohold", dut.hold_vld, 1'b0);
        cycle();

        // Reset while a held load/store is stalled
        drive(1'b1, 1'b1, mk_bus(1, 1, 1, 5'd9, 32'h0, 32'hbfc0_0040), 32'h0);
        cycle();
        drive(1'b0, 1'b0, 72'd0, 32'h55);
        cycle();
        drive(1'b0, 1'b0, 72'd0, 32'h0);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        drive(1'b1, 1'b0, 72'd0, 32'h0);
        check("rst_valid", ms_to_ws_valid, 1'b0);
        check("rst_hold", dut.hold_vld, 1'b0);
        check("rst_MS_dest", MS_dest, 5'd0);
        check("rst_mem_we", mem_we, 1'b0);
        cycle();

        // ALU op with dest 7: bypass depends on build, writeback bus does not
        drive(1'b1, 1'b1, mk_bus(0, 0, 1, 5'd7, 32'hcafe_0007, 32'hbfc0_0050), 32'h0);
        cycle();
        drive(1'b1, 1'b0, 72'd0, 32'h0);
        check("d7_bus", ms_to_ws_bus, {1'b1, 5'd7, 32'hcafe_0007, 32'hbfc0_0050});
`ifdef MS_FWD_EN
        check("d7_MS_dest", MS_dest, 5'd7);
        check("d7_ds_result", ms_to_ds_result, 32'hcafe_0007);
`else
        check("d7_MS_dest", MS_dest, 5'd0);
        check("d7_ds_result", ms_to_ds_result, 32'd0);
`endif
        cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                  {$urandom(), $urandom(), $urandom()} & 72'hff_ffff_ffff_ffff_ffff,
                  $urandom());
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
